// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types and constants for the memory BIST initiator.
//   state_e      - controller states
//   PAT_*        - pattern_sel encodings
//   NUM_LOCS     - locations swept per run (all banks x all words)
//   DRAIN_CYCLES - cycles spent after the last read to compare its data
package mem_bist_pkg;
    localparam int BANK_W_DEF   = 2;
    localparam int ADDR_W_DEF   = 4;
    localparam int DATA_W_DEF   = 8;
    localparam int CNT_W_DEF    = 16;
    localparam int NUM_LOCS     = 2 ** (BANK_W_DEF + ADDR_W_DEF);
    localparam int DRAIN_CYCLES = 1;

    localparam logic [1:0] PAT_CONST   = 2'd0;
    localparam logic [1:0] PAT_XOR_IDX = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_ADD_IDX = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;
endpackage

// File: rtl/mem_bist_if.sv
// mem_bist_if: request/response bundle between the BIST initiator and the
// banked single-port memory.
//   mem_bank/mem_addr - location select (bank is the upper index bits)
//   mem_data_in       - write data
//   mem_we            - write enable
//   mem_data_out      - registered read data, one-cycle latency
interface mem_bist_if #(
    parameter int BANK_W = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [BANK_W-1:0] mem_bank;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_we;
    logic [DATA_W-1:0] mem_data_out;

    modport master (output mem_bank, mem_addr, mem_data_in, mem_we,
                    input  mem_data_out);
    modport slave  (input  mem_bank, mem_addr, mem_data_in, mem_we,
                    output mem_data_out);
endinterface

// File: rtl/mem_bist_patgen.sv
// mem_bist_patgen: combinational test-pattern generator.
//   sel_i/seed_i      - pattern select and seed
//   bank_i/addr_i     - location; index i = {bank, addr}
//   data_o            - pattern value for that location
module mem_bist_patgen
    import mem_bist_pkg::*;
#(
    parameter int BANK_W = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic [BANK_W-1:0] bank_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);
    logic [DATA_W-1:0] idx;

    always_comb begin
        idx    = DATA_W'({bank_i, addr_i});
        data_o = seed_i;
        case (sel_i)
            PAT_CONST:   data_o = seed_i;
            PAT_XOR_IDX: data_o = seed_i ^ idx;
            PAT_CHECKER: data_o = addr_i[0] ? ~seed_i : seed_i;
            PAT_ADD_IDX: data_o = seed_i + idx;
            default:     data_o = seed_i;
        endcase
    end
endmodule

// File: rtl/mem_bist.sv
// mem_bist: built-in self-test initiator for a banked single-port memory.
// Writes a pattern to every location, reads each back and compares.
//   clk/rst_n           - clock, async active-low reset
//   start               - begin a run (ignored while busy)
//   pattern_sel/seed    - pattern configuration, sampled with start
//   mem                 - memory request/response bundle (master side)
//   busy/done/pass      - run status
//   err_count           - saturating mismatch count
//   fail_*              - first mismatch capture
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int BANK_W = BANK_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] seed,
    mem_bist_if.master        mem,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic              fail_valid,
    output logic [BANK_W-1:0] fail_bank,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [DATA_W-1:0] fail_expected
);
    localparam int LOC_W = BANK_W + ADDR_W;

    state_e            state_q;
    logic [1:0]        sel_q;
    logic [DATA_W-1:0] seed_q;
    logic [BANK_W-1:0] bank_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    // compare stage: describes the read whose data arrives this cycle
    logic              stg_vld_q;
    logic [LOC_W-1:0]  stg_loc_q;
    logic [DATA_W-1:0] stg_exp_q;
    logic              busy_q, done_q, fvld_q;
    logic [CNT_W-1:0]  err_q;
    logic [BANK_W-1:0] fbank_q;
    logic [ADDR_W-1:0] faddr_q;
    logic [DATA_W-1:0] fdata_q, fexp_q;

    logic [LOC_W-1:0]  loc, nxt_loc;
    logic              launch, mismatch;
    logic [1:0]        pat_sel;
    logic [DATA_W-1:0] pat_seed, wr_pat, exp_pat;

    // The outputs always hold the location currently being issued, so it
    // doubles as the sweep index.
    assign loc      = {bank_q, addr_q};
    assign launch   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign nxt_loc  = launch ? '0 : loc + 1'b1;
    // On launch the first write must already use the new configuration.
    assign pat_sel  = launch ? pattern_sel : sel_q;
    assign pat_seed = launch ? seed : seed_q;
    assign mismatch = stg_vld_q && (mem.mem_data_out != stg_exp_q);

    mem_bist_patgen #(.BANK_W(BANK_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pat (
        .sel_i(pat_sel), .seed_i(pat_seed),
        .bank_i(nxt_loc[LOC_W-1:ADDR_W]), .addr_i(nxt_loc[ADDR_W-1:0]),
        .data_o(wr_pat)
    );

    mem_bist_patgen #(.BANK_W(BANK_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_exp_pat (
        .sel_i(sel_q), .seed_i(seed_q),
        .bank_i(bank_q), .addr_i(addr_q),
        .data_o(exp_pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            seed_q    <= '0;
            bank_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            stg_vld_q <= 1'b0;
            stg_loc_q <= '0;
            stg_exp_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fvld_q    <= 1'b0;
            err_q     <= '0;
            fbank_q   <= '0;
            faddr_q   <= '0;
            fdata_q   <= '0;
            fexp_q    <= '0;
        end else begin
            stg_vld_q <= (state_q == ST_READ);
            stg_loc_q <= loc;
            stg_exp_q <= exp_pat;

            if (mismatch) begin
                if (err_q != '1) err_q <= err_q + 1'b1;
                if (!fvld_q) begin
                    fvld_q  <= 1'b1;
                    fbank_q <= stg_loc_q[LOC_W-1:ADDR_W];
                    faddr_q <= stg_loc_q[ADDR_W-1:0];
                    fdata_q <= mem.mem_data_out;
                    fexp_q  <= stg_exp_q;
                end
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sel_q   <= pattern_sel;
                        seed_q  <= seed;
                        err_q   <= '0;
                        fvld_q  <= 1'b0;
                        fbank_q <= '0;
                        faddr_q <= '0;
                        fdata_q <= '0;
                        fexp_q  <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        we_q    <= 1'b1;
                        {bank_q, addr_q} <= nxt_loc;
                        wdata_q <= wr_pat;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (&loc) begin
                        we_q    <= 1'b0;
                        {bank_q, addr_q} <= '0;
                        state_q <= ST_READ;
                    end else begin
                        {bank_q, addr_q} <= nxt_loc;
                        wdata_q <= wr_pat;
                    end
                end
                ST_READ: begin
                    if (&loc) state_q <= ST_DRAIN;
                    else      {bank_q, addr_q} <= nxt_loc;
                end
                ST_DRAIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem.mem_bank    = bank_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_data_in = wdata_q;
    assign mem.mem_we      = we_q;

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = done_q && (err_q == '0);
    assign err_count     = err_q;
    assign fail_valid    = fvld_q;
    assign fail_bank     = fbank_q;
    assign fail_addr     = faddr_q;
    assign fail_data     = fdata_q;
    assign fail_expected = fexp_q;
endmodule
